// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one backing-memory line port between the I-cache and the D-cache.
//
// One requester owns memory at a time (GRANT_I / GRANT_D). Ownership is decided in IDLE
// from the enables sampled at the clock edge. While a port owns memory:
//   - its strobes, address and write data go straight to memory;
//   - the memory response goes straight back to it.
// A D write-back completion locks the next grant to D, so the refill that follows it
// cannot be split from it by an I access. A saturating counter bounds how many
// consecutive contended D grants the I-port can lose.
//
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   in_i_*/out_i_*                   I-cache line read port (read-only)
//   in_d_*/out_d_*                   D-cache line read / write-back port
//   out_mem_*/in_mem_*               backing-memory line port
//   out_grant_i, out_grant_d         current owner of the memory port
//
// Optional build macro MEM_ARB_PERF_EN adds the performance counters
//   out_i_grants, out_d_grants and out_wait_cycles.
// These are free-running and wrap.
module mem_arbiter #(
  parameter int unsigned CACHE_LINE_SIZE = 128,
  parameter int unsigned STARVE_LIMIT    = 4
) (
`ifdef MEM_ARB_PERF_EN
  output logic [31:0]                out_i_grants,
  output logic [31:0]                out_d_grants,
  output logic [31:0]                out_wait_cycles,
`endif
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_i_read_en,
  input  logic [31:0]                in_i_addr,
  output logic [CACHE_LINE_SIZE-1:0] out_i_read_data,
  output logic                       out_i_ready,
  input  logic                       in_d_read_en,
  input  logic                       in_d_write_en,
  input  logic [31:0]                in_d_addr,
  input  logic [CACHE_LINE_SIZE-1:0] in_d_write_data,
  output logic [CACHE_LINE_SIZE-1:0] out_d_read_data,
  output logic                       out_d_ready,
  output logic                       out_mem_read_en,
  output logic                       out_mem_write_en,
  output logic [31:0]                out_mem_addr,
  output logic [CACHE_LINE_SIZE-1:0] out_mem_write_data,
  input  logic [CACHE_LINE_SIZE-1:0] in_mem_read_data,
  input  logic                       in_mem_ready,
  output logic                       out_grant_i,
  output logic                       out_grant_d
);

  typedef enum logic [1:0] {StIdle, StGrantI, StGrantD} state_e;

  localparam logic [3:0] StarveLimit = 4'(STARVE_LIMIT);

  state_e     state_q;
  logic [3:0] starve_q;
  logic       d_lock_q;

  logic i_req, d_req;
  logic lock_win, starved;
  logic pick_i, pick_d, starve_inc;

  assign i_req = in_i_read_en;
  assign d_req = in_d_read_en | in_d_write_en;

  // IDLE arbitration decision for the coming edge.
  always_comb begin
    lock_win   = d_lock_q & d_req;
    starved    = (starve_q >= StarveLimit);
    pick_i     = (state_q == StIdle) & i_req & ~lock_win & (~d_req | starved);
    pick_d     = (state_q == StIdle) & d_req & ~pick_i;
    // Only a contended, unlocked D win counts against the I-port.
    starve_inc = pick_d & i_req & ~lock_win;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      starve_q <= 4'd0;
      d_lock_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (lock_win || !d_req) begin
            d_lock_q <= 1'b0;
          end
          if (pick_i) begin
            state_q  <= StGrantI;
            starve_q <= 4'd0;
          end else if (pick_d) begin
            state_q <= StGrantD;
            if (starve_inc && (starve_q != 4'd15)) begin
              starve_q <= starve_q + 4'd1;
            end
          end
        end
        StGrantI: begin
          if (in_mem_ready) begin
            state_q <= StIdle;
          end
        end
        StGrantD: begin
          if (in_mem_ready) begin
            state_q  <= StIdle;
            // A finished write-back reserves the next grant for its refill.
            d_lock_q <= in_d_write_en;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Memory port and responses follow the owner combinationally; all zero in IDLE.
  always_comb begin
    out_mem_read_en    = 1'b0;
    out_mem_write_en   = 1'b0;
    out_mem_addr       = 32'd0;
    out_mem_write_data = '0;
    out_i_ready        = 1'b0;
    out_i_read_data    = '0;
    out_d_ready        = 1'b0;
    out_d_read_data    = '0;
    unique case (state_q)
      StGrantI: begin
        out_mem_read_en = in_i_read_en;
        out_mem_addr    = in_i_addr;
        out_i_ready     = in_mem_ready;
        out_i_read_data = in_mem_read_data;
      end
      StGrantD: begin
        out_mem_write_en   = in_d_write_en;
        out_mem_read_en    = in_d_read_en & ~in_d_write_en;
        out_mem_addr       = in_d_addr;
        out_mem_write_data = in_d_write_data;
        out_d_ready        = in_mem_ready;
        out_d_read_data    = in_mem_read_data;
      end
      default: ;
    endcase
  end

  assign out_grant_i = (state_q == StGrantI);
  assign out_grant_d = (state_q == StGrantD);

`ifdef MEM_ARB_PERF_EN
  logic [31:0] i_grants_q, d_grants_q, wait_cycles_q;
  logic        waiting;

  assign waiting = ((state_q == StGrantI) & d_req) | ((state_q == StGrantD) & i_req);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_grants_q    <= 32'd0;
      d_grants_q    <= 32'd0;
      wait_cycles_q <= 32'd0;
    end else begin
      if (pick_i) i_grants_q <= i_grants_q + 32'd1;
      if (pick_d) d_grants_q <= d_grants_q + 32'd1;
      if (waiting) wait_cycles_q <= wait_cycles_q + 32'd1;
    end
  end

  assign out_i_grants    = i_grants_q;
  assign out_d_grants    = d_grants_q;
  assign out_wait_cycles = wait_cycles_q;
`endif

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single backing-memory line port between the instruction cache (I-port) and the data cache (D-port).
- Both caches issue 128-bit line read/write requests with level-held enables and wait for a one-cycle ready pulse. This block grants one requester at a time and routes the memory response back to it.
- A write-back is always followed by its refill without interleaving. A starvation counter bounds how long the I-port can be blocked.

Parameters:
- CACHE_LINE_SIZE, 128, line width in bits for memory read/write data.
- STARVE_LIMIT, 4, number of consecutive D grants the I-port may lose while requesting before it is granted first; range 1-15.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- in_i_read_en  input  1  I-cache line read request (I-port is read-only)
- in_i_addr  input  32  I-cache line address
- out_i_read_data  output  CACHE_LINE_SIZE  line returned to I-cache
- out_i_ready  output  1  one-cycle completion pulse to I-cache
- in_d_read_en  input  1  D-cache line read request
- in_d_write_en  input  1  D-cache line write-back request
- in_d_addr  input  32  D-cache line address
- in_d_write_data  input  CACHE_LINE_SIZE  D-cache write-back line
- out_d_read_data  output  CACHE_LINE_SIZE  line returned to D-cache
- out_d_ready  output  1  one-cycle completion pulse to D-cache
- out_mem_read_en  output  1  memory read strobe (level)
- out_mem_write_en  output  1  memory write strobe (level)
- out_mem_addr  output  32  memory address
- out_mem_write_data  output  CACHE_LINE_SIZE  memory write data
- in_mem_read_data  input  CACHE_LINE_SIZE  memory read data
- in_mem_ready  input  1  memory completion pulse
- out_grant_i  output  1  I-port currently owns memory
- out_grant_d  output  1  D-port currently owns memory

Behaviour:
- Clock and reset are fixed: one clock, clk; reset is asynchronous and active-high, named reset.
- On reset:
  - state=IDLE; grants=0; starve_cnt=0; d_lock=0.
  - out_*_ready=0, out_mem_read_en=0, out_mem_write_en=0.
  - out_mem_addr=0, out_mem_write_data=0.
  - Reset asserted mid-transaction abandons it; a late in_mem_ready after reset is ignored.
- States: IDLE, GRANT_I, GRANT_D.
- IDLE, arbitration is sampled at the clock edge and the grant is registered:
  - d_lock=1 and D requesting -> GRANT_D, clear d_lock.
  - Else if I and D both requesting: starve_cnt>=STARVE_LIMIT -> GRANT_I; otherwise -> GRANT_D and starve_cnt+=1.
  - Else if only I requesting -> GRANT_I. Else if only D requesting -> GRANT_D.
  - starve_cnt clears whenever GRANT_I is entered. It saturates at 15.
  - d_lock clears if D is not requesting in IDLE.
- GRANT_x:
  - Memory strobes, address and write data are driven combinationally from the granted port.
  - The non-granted port sees ready=0 and read_data=0.
  - The I-port never drives a write.
  - D with both read_en and write_en set: write has priority, and read_en is masked to memory.
- Completion:
  - in_mem_ready in GRANT_x -> out_x_ready=1 in the same cycle (combinational), read data passed through, next state=IDLE.
  - A D write completion sets d_lock=1. This guarantees the following refill is granted before any I request.
- Latency: request raised at edge N -> memory strobe visible after edge N+1 -> ready returned in the same cycle as in_mem_ready.
  - Requester may drop its enable in the cycle after ready.
  - Minimum one IDLE cycle between transactions.
- If the granted requester drops its enable before ready, the strobes fall but the grant is held until in_mem_ready. Memory must still complete the transaction.
- in_mem_ready while IDLE is ignored.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- Defined:
  - Adds outputs out_i_grants[31:0], out_d_grants[31:0] and out_wait_cycles[31:0].
  - out_i_grants and out_d_grants increment on entry to GRANT_I and GRANT_D respectively.
  - out_wait_cycles increments every cycle in which a non-granted port is requesting.
  - All three wrap at 2^32 and reset to 0.
- Undefined: these ports and counters do not exist; arbitration behaviour is identical.

Test Plan:
- Lone I read, addr=0x100; memory returns 0xA5..A5 after 3 cycles -> out_mem_addr=0x100, out_i_ready pulses once with that data, out_d_ready stays 0.
- I and D reads raised in the same cycle, STARVE_LIMIT=4 -> D granted first, then I.
- D write-back to 0x200 then refill from 0x300, with I requesting throughout -> write to 0x200, then read of 0x300 with no I grant in between (d_lock), then I.
- D requests continuously while I is held for 6 D transactions, STARVE_LIMIT=4 -> I granted after exactly 4 D grants; starve_cnt returns to 0.
- Reset asserted during GRANT_D, followed by a late in_mem_ready -> all outputs 0 immediately (asynchronously), no ready pulse, state IDLE.
- With MEM_ARB_PERF_EN defined: 3 I grants and 2 D grants, 5 contention cycles -> counters read 3, 2, 5.
